// File: rtl/vga_rx.sv
// vga_rx: receiving end of the packed VGA pin interface.
// Registers the 8-bit RGB222/sync bus and DE, recovers pixel coordinates and
// colour, measures line/frame timing against the expected geometry and
// declares lock after LOCK_FRAMES consecutive conforming frames.
// Optional feature: define VGA_RX_CRC_EN to compute a CRC-16-CCITT over the
// pixels of each frame; otherwise frame_crc is tied to zero.
module vga_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        de_in,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [5:0]  px_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  // Input stage and edge detection
  logic [7:0] vga_q;
  logic       de_q;
  logic       hs_prev;
  logic       vs_prev;
  logic       de_prev;
  logic       hs_assert;
  logic       vs_assert;
  logic       de_fall;

  // Register the pins once, then keep a delayed copy of syncs/DE for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_q   <= '0;
      de_q    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample pre-edge
      // values; blocking ones would collapse this delay chain into wires.
      vga_q   <= vga_in;
      de_q    <= de_in;
      hs_prev <= vga_q[7];
      vs_prev <= vga_q[3];
      de_prev <= de_q;
    end
  end

  // Syncs are active-low, so "assert" is a 1->0 transition.
  assign hs_assert = hs_prev & ~vga_q[7];
  assign vs_assert = vs_prev & ~vga_q[3];
  assign de_fall   = de_prev & ~de_q;

  // Pixel path
  logic [9:0] col;
  logic [9:0] row;

  // Output register: one strobe per DE-high cycle with its coordinates and
  // the colour unpacked from {hs, b0, g0, r0, vs, b1, g1, r1}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      col         <= '0;
      row         <= '0;
    end else begin
      px_valid    <= de_q;
      frame_start <= vs_assert;
      px_rgb      <= {vga_q[0], vga_q[4], vga_q[1], vga_q[5], vga_q[2], vga_q[6]};
      if (de_q) begin
        px_x <= col;
        px_y <= row;
        col  <= col + 10'd1;
      end else if (de_fall) begin
        col <= '0;
      end
      if (vs_assert) begin
        row <= '0;
      end else if (de_fall) begin
        row <= row + 10'd1;
      end
    end
  end

  // Timing measurement
  state_t      state;
  state_t      state_n;
  logic [2:0]  good;
  logic [2:0]  good_n;
  logic [3:0]  good_inc;
  logic        err_h_n;
  logic        err_v_n;
  logic        measuring;
  logic [10:0] h_cnt;
  logic [9:0]  de_w;
  logic [9:0]  v_cnt;
  logic [9:0]  de_h;
  logic        bad_h;
  logic [9:0]  v_cnt_eff;
  logic [9:0]  de_h_eff;
  logic        line_bad;
  logic        frame_bad_h;
  logic        frame_bad_v;
  logic        frame_bad;
  logic        h_sat;
  logic        v_sat;

  assign measuring = (state != SEARCH);
  assign h_sat     = (h_cnt == '1);
  assign v_sat     = (v_cnt == '1);
  assign good_inc  = {1'b0, good} + 4'd1;

  // Line and frame conformance; a coincident hsync counts toward the frame
  // that the vsync closes, and its line check is folded in as well.
  always_comb begin
    v_cnt_eff   = v_cnt + {9'd0, hs_assert};
    de_h_eff    = de_h + {9'd0, de_fall};
    line_bad    = measuring & hs_assert &
                  (((h_cnt + 11'd1) != H_TOTAL_C) |
                   ((de_w != '0) & (de_w != H_ACTIVE_C)));
    frame_bad_h = bad_h | line_bad;
    frame_bad_v = (v_cnt_eff != V_TOTAL_C) | (de_h_eff != V_ACTIVE_C);
    frame_bad   = frame_bad_h | frame_bad_v;
  end

  // Measurement counters run only while acquiring or locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      de_w  <= '0;
      v_cnt <= '0;
      de_h  <= '0;
      bad_h <= 1'b0;
    end else if (!measuring || (state_n == SEARCH)) begin
      h_cnt <= '0;
      de_w  <= '0;
      v_cnt <= '0;
      de_h  <= '0;
      bad_h <= 1'b0;
    end else begin
      if (hs_assert) begin
        h_cnt <= '0;
        de_w  <= '0;
      end else begin
        if (!h_sat) h_cnt <= h_cnt + 11'd1;
        if (de_q && (de_w != '1)) de_w <= de_w + 10'd1;
      end
      if (vs_assert) begin
        v_cnt <= '0;
        de_h  <= '0;
        bad_h <= 1'b0;
      end else begin
        if (hs_assert && !v_sat) v_cnt <= v_cnt + 10'd1;
        if (de_fall && (de_h != '1)) de_h <= de_h + 10'd1;
        bad_h <= frame_bad_h;
      end
    end
  end

  // Lock state, good-frame count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      good  <= '0;
      err_h <= 1'b0;
      err_v <= 1'b0;
    end else begin
      state <= state_n;
      good  <= good_n;
      err_h <= err_h_n;
      err_v <= err_v_n;
    end
  end

  // Next-state logic; errors are only recorded when losing an existing lock.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n = state;
    good_n  = good;
    err_h_n = err_h;
    err_v_n = err_v;
    case (state)
      SEARCH: begin
        if (vs_assert) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      MEASURE: begin
        if (vs_assert) begin
          if (frame_bad) begin
            good_n = '0;
          end else begin
            good_n = good_inc[2:0];
            if (good_inc >= LOCK_C) state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (vs_assert && frame_bad) begin
          err_h_n = err_h | frame_bad_h;
          err_v_n = err_v | frame_bad_v;
          good_n  = '0;
          state_n = MEASURE;
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
      end
    endcase
    // A saturated counter means the sync disappeared: restart acquisition.
    if (measuring && (h_sat || v_sat)) begin
      state_n = SEARCH;
      good_n  = '0;
      if (state == LOCKED) begin
        err_h_n = err_h | h_sat;
        err_v_n = err_v | v_sat;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_next;

  // CRC-16-CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign crc_next = px_valid ? crc_step(crc, {2'b00, px_rgb}) : crc;

  // Accumulate over the frame's pixels, publish and restart at each vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else if (frame_start) begin
      frame_crc <= crc_next;
      crc       <= 16'hFFFF;
    end else begin
      crc <= crc_next;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed bench for vga_rx on a reduced 48x24 geometry
// (32x16 active) so full frames stay short.
module tb_vga_rx;

  localparam int HT    = 48;
  localparam int VT    = 24;
  localparam int HA    = 32;
  localparam int VA    = 16;
  localparam int HS_W  = 4;   // hsync low clocks at line start
  localparam int H_DE0 = 8;   // first DE clock in a line
  localparam int VS_W  = 2;   // vsync low lines at frame start
  localparam int V_DE0 = 4;   // first active line

  localparam logic [5:0] COL_A = 6'b000100;
  localparam logic [5:0] COL_B = 6'b100001;
  localparam logic [5:0] COL_C = 6'b011010;

  typedef struct {
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic        de_in = 1'b0;
  logic        px_valid;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic [5:0]  px_rgb;
  logic        frame_start;
  logic        locked;
  logic        err_h;
  logic        err_v;
  logic [15:0] frame_crc;

  vga_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .de_in(de_in),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_start(frame_start), .locked(locked), .err_h(err_h), .err_v(err_v),
    .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pipeline scoreboard: what was driven two clocks ago must appear now.
  pix_t       pipe0 = '{1'b0, 10'd0, 10'd0, 6'd0};
  pix_t       pipe1 = '{1'b0, 10'd0, 10'd0, 6'd0};
  int         px_cnt = 0;
  int         px_bad = 0;
  logic [9:0] last_x, last_y, nrow_x, nrow_y;
  logic       s_lk [4];
  logic       s_fs [4];
  logic       s_eh [4];
  logic       s_ev [4];
  logic [15:0] s_crc;

  function automatic logic [7:0] pack(input logic hs, input logic vs, input logic [5:0] rgb);
    // rgb = {r1, r0, g1, g0, b1, b0}; bus = {hs, b0, g0, r0, vs, b1, g1, r1}
    return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
  endfunction

  function automatic logic [15:0] crc_zeros(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n * 8; k++) begin
      if (c[15]) c = (c << 1) ^ 16'h1021;
      else       c = c << 1;
    end
    return c;
  endfunction

  task automatic step(input logic [7:0] bus, input logic de, input int x, input int y,
                      input int l, input int c);
    @(negedge clk);
    if (pipe1.de) begin
      px_cnt++;
      if (px_valid !== 1'b1 || px_x !== pipe1.x || px_y !== pipe1.y || px_rgb !== pipe1.rgb)
        px_bad++;
      if (pipe1.x == 10'(HA - 1) && pipe1.y == 10'(VA - 1)) begin
        last_x = px_x;
        last_y = px_y;
      end
      if (pipe1.x == 10'd0 && pipe1.y == 10'(VA - 1)) begin
        nrow_x = px_x;
        nrow_y = px_y;
      end
    end else if (px_valid !== 1'b0) begin
      px_bad++;
    end
    if (l == 0 && c >= 0 && c < 4) begin
      s_lk[c] = locked;
      s_fs[c] = frame_start;
      s_eh[c] = err_h;
      s_ev[c] = err_v;
    end
    if (l == 0 && c == 10) s_crc = frame_crc;
    pipe1  = pipe0;
    pipe0  = '{de, 10'(x), 10'(y), bus == 8'h00 ? 6'd0 : 6'd0};
    pipe0.rgb = {bus[0], bus[4], bus[1], bus[5], bus[2], bus[6]};
    vga_in = bus;
    de_in  = de;
  endtask

  task automatic drive_range(input int l, input int c0, input int c1, input logic [5:0] rgb);
    for (int c = c0; c <= c1; c++) begin
      logic hs, vs, de;
      hs = (c >= HS_W);
      vs = (l >= VS_W);
      de = (l >= V_DE0) && (l < V_DE0 + VA) && (c >= H_DE0) && (c < H_DE0 + HA);
      step(pack(hs, vs, de ? rgb : 6'd0), de, c - H_DE0, l - V_DE0, l, c);
    end
  endtask

  task automatic drive_frame(input int short_line, input logic [5:0] rgb);
    px_cnt = 0;
    px_bad = 0;
    last_x = '1; last_y = '1; nrow_x = '1; nrow_y = '1;
    for (int l = 0; l < VT; l++)
      drive_range(l, 0, (l == short_line) ? HT - 2 : HT - 1, rgb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h88, 1'b0, 0, 0, -1, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // reset state
    check("rst_px_valid", px_valid, 0);
    check("rst_px_x", px_x, 0);
    check("rst_px_y", px_y, 0);
    check("rst_px_rgb", px_rgb, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_err_h", err_h, 0);
    check("rst_err_v", err_v, 0);
    check("rst_frame_crc", frame_crc, 0);
    rst_n = 1'b1;
    idle(4);

    // acquisition: SEARCH -> MEASURE -> good 1 -> LOCKED
    drive_frame(-1, COL_A);
    check("f1_locked", s_lk[2], 0);
    check("f1_px_count", px_cnt, HA * VA);
    check("f1_px_bad", px_bad, 0);
    check("f1_last_x", last_x, HA - 1);
    check("f1_last_y", last_y, VA - 1);
    check("f1_nrow_x", nrow_x, 0);
    check("f1_nrow_y", nrow_y, VA - 1);
    drive_frame(-1, COL_A);
    check("f2_locked", s_lk[2], 0);
    check("f2_px_count", px_cnt, HA * VA);
    drive_frame(-1, COL_B);
    check("f3_locked_c1", s_lk[1], 0);
    check("f3_locked_c2", s_lk[2], 1);
    check("f3_fs_c1", s_fs[1], 0);
    check("f3_fs_c2", s_fs[2], 1);
    check("f3_fs_c3", s_fs[3], 0);
    check("f3_err_h", s_eh[2], 0);
    check("f3_err_v", s_ev[2], 0);
    check("f3_px_bad", px_bad, 0);
    drive_frame(-1, COL_C);
    check("f4_locked", s_lk[2], 1);
    check("f4_px_count", px_cnt, HA * VA);
    check("f4_px_bad", px_bad, 0);

    // hsync lost while locked
    for (int l = 0; l < 3; l++) drive_range(l, 0, HT - 1, COL_A);
    check("hl_locked_start", s_lk[2], 1);
    idle(1950);
    check("hl_locked_before_sat", locked, 1);
    check("hl_err_h_before_sat", err_h, 0);
    idle(100);
    check("hl_locked_after_sat", locked, 0);
    check("hl_err_h_after_sat", err_h, 1);
    check("hl_err_v_after_sat", err_v, 0);

    // relock from SEARCH
    drive_frame(-1, COL_A);
    check("g1_locked", s_lk[2], 0);
    drive_frame(-1, COL_A);
    check("g2_locked", s_lk[2], 0);
    drive_frame(-1, COL_A);
    check("g3_locked", s_lk[2], 1);
    check("g3_err_h_sticky", s_eh[2], 1);

    // reset mid-frame while locked
    for (int l = 0; l < 10; l++) drive_range(l, 0, HT - 1, COL_B);
    drive_range(10, 0, 20, COL_B);
    check("pre_rst_locked", locked, 1);
    check("pre_rst_px_valid", px_valid, 1);
    check("pre_rst_px_x", px_x, 10);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_px_valid", px_valid, 0);
    check("mid_rst_px_x", px_x, 0);
    check("mid_rst_px_y", px_y, 0);
    check("mid_rst_px_rgb", px_rgb, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_err_h", err_h, 0);
    check("mid_rst_err_v", err_v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pipe0.de = 1'b0;
    pipe1.de = 1'b0;
    drive_range(10, 21, HT - 1, COL_B);
    for (int l = 11; l < VT; l++) drive_range(l, 0, HT - 1, COL_B);
    drive_frame(-1, COL_C);
    check("h1_locked", s_lk[2], 0);
    check("h1_px_count", px_cnt, HA * VA);
    check("h1_px_bad", px_bad, 0);
    drive_frame(-1, COL_C);
    check("h2_locked", s_lk[2], 0);

    // one short line while locked
    drive_frame(10, COL_A);
    check("h3_locked", s_lk[2], 1);
    drive_frame(-1, COL_A);
    check("h4_locked_c1", s_lk[1], 1);
    check("h4_err_h_c1", s_eh[1], 0);
    check("h4_locked_c2", s_lk[2], 0);
    check("h4_err_h_c2", s_eh[2], 1);
    check("h4_err_v_c2", s_ev[2], 0);
    drive_frame(-1, COL_A);
    check("h5_locked", s_lk[2], 0);
    drive_frame(-1, 6'd0);
    check("h6_locked", s_lk[2], 1);
    check("h6_err_h_sticky", s_eh[2], 1);
    check("h6_px_bad", px_bad, 0);
    drive_frame(-1, COL_A);
`ifdef VGA_RX_CRC_EN
    check("black_frame_crc", s_crc, crc_zeros(HA * VA));
`else
    check("black_frame_crc", s_crc, 0);
`endif
    check("h7_locked", s_lk[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
